fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
Parametrised operand-forwarding and load-use hazard unit for the in-order RISC-V pipeline, sitting between decode and the ALU. It keeps a DEPTH-entry scoreboard of in-flight destination registers and forwards the youngest matching result to op1/op2/store_data. It stalls decode only while a matching load's data is not yet available, and handles bubbles and flushes. It extends the fixed 2-entry, single-cycle-load scheme to configurable depth and load latency, adds x0 suppression, youngest-wins priority and a forwarded store-data path.

Parameters:
XLEN, 32, datapath width
REG_BITS, 5, register index width
DEPTH, 3, tracked in-flight stages (entry 0 = EX, 1 = MEM, 2 = WB, ...)
LOAD_STAGE, 1, first entry index whose stage_data carries valid load data (1 = MEM output)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
dec_valid  in  1  decode holds a valid instruction
rs1, rs2  in  REG_BITS  source indices
rs1_en, rs2_en  in  1  source actually read
rd  in  REG_BITS  destination index
rd_en  in  1  instruction writes rd
imm_en  in  1  op2 takes the immediate
load  in  1  instruction is a load
opcode  in  7  major opcode
pc, imm, data1, data2  in  XLEN  decode PC, immediate, register-file reads
stage_data  in  DEPTH*XLEN  result bus of entry i at bits [i*XLEN +: XLEN]
flush  in  1  kill the instruction in decode
stall  out  1  hold PC and IF/ID; push a bubble
op1, op2  out  XLEN  ALU operands
store_data  out  XLEN  forwarded rs2 value
fwd1_sel, fwd2_sel  out  $clog2(DEPTH+1)  0 = register file, i+1 = entry i (debug/verification)

Behaviour:
- Scoreboard entry: {valid, rd, is_load}. On rst, all entries are cleared to 0 and all outputs settle to their combinational values (stall=0).
- Every cycle, entry[i] <= entry[i-1] for i ≥ 1. Entry[0] <= {dec_valid & rd_en & (rd≠0) & ~stall & ~flush, rd, load}.
- Stall and flush both insert a bubble. Flush has priority over stall, and stall is forced to 0 while flush=1.
- Match for source s: rsX_en & rsX≠0 & entry[i].valid & entry[i].rd==rsX. The lowest index (youngest) wins. No match selects data1/data2.
- Load-use: stall = dec_valid & ~flush & (hazard on rs1 | hazard on rs2). A hazard exists when the winning match has is_load=1 and index < LOAD_STAGE. The stall deasserts by itself once the load shifts to LOAD_STAGE. Total stall length = LOAD_STAGE − index, e.g. 1 cycle for back-to-back with the default.
- While stall=1, op1/op2 are don't-care (the ALU consumes a bubble). The bench checks values only when stall=0.
- fwd_rs1/fwd_rs2 are the forwarded source values. Operand mux:
  - branch (1100011): op1=fwd_rs1, op2=fwd_rs2
  - jal (1101111): op1=pc, op2=imm
  - jalr (1100111): op1=fwd_rs1, op2=imm
  - otherwise: op1=fwd_rs1; op2 = imm_en ? imm : fwd_rs2
- store_data = fwd_rs2, always.
- The rs1==rs2 case is legal, and both operands get the same forwarded value.
- All outputs are combinational from state plus inputs. Latency is 0 cycles from inputs to op1/op2/stall.
- Reset mid-operation clears the scoreboard at once. The next instruction then reads the register file.

Decomposition:
- Shared package `rv_pkg`: opcode constants OP_BRANCH, OP_JAL, OP_JALR, OP_LOAD, OP_STORE, and the scoreboard entry struct.
- One sub-module, `fwd_match_sel`: priority matcher instantiated per source (rs, en, entries → sel, hit_load).
- Operand mux and scoreboard shift register live in the top module.

Test Plan:
- Reset, then an ALU op with rs1=5, rs2=6, no history → op1=data1, op2=data2, both fwd sel=0, stall=0.
- addi x3 then add x4,x3,x7 back-to-back, stage_data[0]=0x0000_0011 → op1=0x11, fwd1_sel=1, stall=0.
- lw x8 then add x9,x8,x1 → stall=1 for exactly 1 cycle. The next cycle, with stage_data[1]=0xDEAD_BEEF, gives op1=0xDEADBEEF and fwd1_sel=2. Repeat with LOAD_STAGE=2: 2-cycle stall.
- Writes to x2 at entries 0 and 2 (values 0xA and 0xB), then sw with rs2=2 → store_data=0xA (youngest wins), op2=imm.
- addi x0,x0,5 then add x1,x0,x0 → no forward, op1=op2=data1=0; an rs1_en=0 instruction never stalls.
- Load-use stall with flush=1 in the same cycle → stall=0 and a bubble is pushed. Assert rst while a stall is active → stall=0 next cycle, and the scoreboard is empty.

Source files
------------

// File: rtl/rv_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rv_pkg : opcodes and scoreboard entry type for the forwarding unit    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package rv_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    // rd is stored at a fixed upper-bound width so the type stays unparametrised
    localparam int MAX_REG_BITS = 8;

    typedef struct packed {
        logic                    valid;
        logic [MAX_REG_BITS-1:0] rd;
        logic                    is_load;
    } sb_entry_t;

endpackage
`default_nettype wire

// File: rtl/fwd_hazard_unit_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fwd_hazard_unit_if : decode-side and operand-side bundle              |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface fwd_hazard_unit_if #(
    parameter int XLEN     = 32,
    parameter int REG_BITS = 5,
    parameter int DEPTH    = 3
) ();
    localparam int SEL_W = $clog2(DEPTH + 1);

    logic                  dec_valid;
    logic [REG_BITS-1:0]   rs1;
    logic [REG_BITS-1:0]   rs2;
    logic                  rs1_en;
    logic                  rs2_en;
    logic [REG_BITS-1:0]   rd;
    logic                  rd_en;
    logic                  imm_en;
    logic                  load;
    logic [6:0]            opcode;
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       imm;
    logic [XLEN-1:0]       data1;
    logic [XLEN-1:0]       data2;
    logic [DEPTH*XLEN-1:0] stage_data;
    logic                  flush;
    logic                  stall;
    logic [XLEN-1:0]       op1;
    logic [XLEN-1:0]       op2;
    logic [XLEN-1:0]       store_data;
    logic [SEL_W-1:0]      fwd1_sel;
    logic [SEL_W-1:0]      fwd2_sel;

    modport master (
        output dec_valid, rs1, rs2, rs1_en, rs2_en, rd, rd_en, imm_en, load,
               opcode, pc, imm, data1, data2, stage_data, flush,
        input  stall, op1, op2, store_data, fwd1_sel, fwd2_sel
    );

    modport slave (
        input  dec_valid, rs1, rs2, rs1_en, rs2_en, rd, rd_en, imm_en, load,
               opcode, pc, imm, data1, data2, stage_data, flush,
        output stall, op1, op2, store_data, fwd1_sel, fwd2_sel
    );
endinterface
`default_nettype wire

// File: rtl/fwd_match_sel.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fwd_match_sel : youngest-wins scoreboard matcher for one source reg   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module fwd_match_sel
    import rv_pkg::*;
#(
    parameter int REG_BITS = 5,
    parameter int DEPTH    = 3,
    parameter int SEL_W    = $clog2(DEPTH + 1)
) (
    input  logic [REG_BITS-1:0]   rs,
    input  logic                  en,
    input  sb_entry_t [DEPTH-1:0] entries,
    output logic [SEL_W-1:0]      sel,
    output logic                  hit_load
);

    // Scan oldest to youngest so the lowest matching index overrides.
    always_comb begin
        sel      = '0;
        hit_load = 1'b0;
        if (en && (rs != '0)) begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (entries[i].valid && (entries[i].rd == MAX_REG_BITS'(rs))) begin
                    sel      = SEL_W'(i + 1);
                    hit_load = entries[i].is_load;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fwd_hazard_unit : operand forwarding and load-use stall generation    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module fwd_hazard_unit
    import rv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_BITS   = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 1
) (
    input  logic             clk,
    input  logic             rst,
    fwd_hazard_unit_if.slave bus
);
    localparam int SEL_W = $clog2(DEPTH + 1);

    sb_entry_t [DEPTH-1:0] r_sb;
    sb_entry_t [DEPTH-1:0] w_sb_next;
    sb_entry_t             w_new_entry;

    logic [SEL_W-1:0] w_sel1;
    logic [SEL_W-1:0] w_sel2;
    logic             w_hit_load1;
    logic             w_hit_load2;
    logic             w_haz1;
    logic             w_haz2;
    logic             w_stall;
    logic [XLEN-1:0]  w_stage [DEPTH];
    logic [XLEN-1:0]  w_fwd_rs1;
    logic [XLEN-1:0]  w_fwd_rs2;
    logic [XLEN-1:0]  w_op1;
    logic [XLEN-1:0]  w_op2;

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_unpack
            assign w_stage[g] = bus.stage_data[g*XLEN +: XLEN];
        end
    endgenerate

    fwd_match_sel #(
        .REG_BITS (REG_BITS),
        .DEPTH    (DEPTH),
        .SEL_W    (SEL_W)
    ) u_match1 (
        .rs       (bus.rs1),
        .en       (bus.rs1_en),
        .entries  (r_sb),
        .sel      (w_sel1),
        .hit_load (w_hit_load1)
    );

    fwd_match_sel #(
        .REG_BITS (REG_BITS),
        .DEPTH    (DEPTH),
        .SEL_W    (SEL_W)
    ) u_match2 (
        .rs       (bus.rs2),
        .en       (bus.rs2_en),
        .entries  (r_sb),
        .sel      (w_sel2),
        .hit_load (w_hit_load2)
    );

    // sel = index+1, so "index < LOAD_STAGE" becomes "sel <= LOAD_STAGE".
    assign w_haz1  = w_hit_load1 && (int'(w_sel1) <= LOAD_STAGE);
    assign w_haz2  = w_hit_load2 && (int'(w_sel2) <= LOAD_STAGE);
    assign w_stall = bus.dec_valid && !bus.flush && (w_haz1 || w_haz2);

    always_comb begin
        w_fwd_rs1 = bus.data1;
        w_fwd_rs2 = bus.data2;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_sel1 == SEL_W'(i + 1)) w_fwd_rs1 = w_stage[i];
            if (w_sel2 == SEL_W'(i + 1)) w_fwd_rs2 = w_stage[i];
        end
    end

    always_comb begin
        w_op1 = w_fwd_rs1;
        w_op2 = bus.imm_en ? bus.imm : w_fwd_rs2;
        case (bus.opcode)
            OP_BRANCH: w_op2 = w_fwd_rs2;
            OP_JAL: begin
                w_op1 = bus.pc;
                w_op2 = bus.imm;
            end
            OP_JALR:   w_op2 = bus.imm;
            default:   ;
        endcase
    end

    assign bus.stall      = w_stall;
    assign bus.op1        = w_op1;
    assign bus.op2        = w_op2;
    assign bus.store_data = w_fwd_rs2;
    assign bus.fwd1_sel   = w_sel1;
    assign bus.fwd2_sel   = w_sel2;

    // Stalled or flushed decode slots enter the pipe as bubbles.
    assign w_new_entry.valid   = bus.dec_valid && bus.rd_en && (bus.rd != '0)
                                 && !w_stall && !bus.flush;
    assign w_new_entry.rd      = MAX_REG_BITS'(bus.rd);
    assign w_new_entry.is_load = bus.load;

    generate
        if (DEPTH > 1) begin : g_shift
            assign w_sb_next = {r_sb[DEPTH-2:0], w_new_entry};
        end else begin : g_single
            assign w_sb_next = w_new_entry;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sb <= '0;
        end else begin
            r_sb <= w_sb_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_fwd_hazard_unit : directed table, hand sequences, random vs model  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_fwd_hazard_unit;
    import rv_pkg::*;

    localparam logic [31:0] PC  = 32'h0000_0100;
    localparam logic [31:0] IMM = 32'h0000_0055;
    localparam logic [31:0] D1  = 32'h0000_1111;
    localparam logic [31:0] D2  = 32'h0000_2222;
    localparam logic [6:0]  OP_ALU = 7'b0110011;
    localparam logic [6:0]  OP_IMM = 7'b0010011;

    typedef struct {
        logic        rst, dv, e1, e2, rde, imme, ld, fl;
        logic [4:0]  rs1, rs2, rd;
        logic [6:0]  op;
        logic [31:0] pc, imm, d1, d2, sd0, sd1, sd2;
    } in_t;

    typedef struct {
        in_t         in;
        bit          st;
        int          s1, s2;
        bit          co;
        logic [31:0] o1, o2, sd;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    in_t  cur;
    int   nchecks = 0;
    int   nerr    = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.XLEN(32), .REG_BITS(5), .DEPTH(3)) bus0 ();
    fwd_hazard_unit_if #(.XLEN(32), .REG_BITS(5), .DEPTH(3)) bus1 ();

    fwd_hazard_unit #(.XLEN(32), .REG_BITS(5), .DEPTH(3), .LOAD_STAGE(1)) u_dut0 (
        .clk (clk), .rst (rst), .bus (bus0)
    );
    fwd_hazard_unit #(.XLEN(32), .REG_BITS(5), .DEPTH(3), .LOAD_STAGE(2)) u_dut1 (
        .clk (clk), .rst (rst), .bus (bus1)
    );

    assign rst = cur.rst;
    assign bus0.dec_valid = cur.dv;   assign bus1.dec_valid = cur.dv;
    assign bus0.rs1 = cur.rs1;        assign bus1.rs1 = cur.rs1;
    assign bus0.rs2 = cur.rs2;        assign bus1.rs2 = cur.rs2;
    assign bus0.rs1_en = cur.e1;      assign bus1.rs1_en = cur.e1;
    assign bus0.rs2_en = cur.e2;      assign bus1.rs2_en = cur.e2;
    assign bus0.rd = cur.rd;          assign bus1.rd = cur.rd;
    assign bus0.rd_en = cur.rde;      assign bus1.rd_en = cur.rde;
    assign bus0.imm_en = cur.imme;    assign bus1.imm_en = cur.imme;
    assign bus0.load = cur.ld;        assign bus1.load = cur.ld;
    assign bus0.opcode = cur.op;      assign bus1.opcode = cur.op;
    assign bus0.pc = cur.pc;          assign bus1.pc = cur.pc;
    assign bus0.imm = cur.imm;        assign bus1.imm = cur.imm;
    assign bus0.data1 = cur.d1;       assign bus1.data1 = cur.d1;
    assign bus0.data2 = cur.d2;       assign bus1.data2 = cur.d2;
    assign bus0.flush = cur.fl;       assign bus1.flush = cur.fl;
    assign bus0.stage_data = {cur.sd2, cur.sd1, cur.sd0};
    assign bus1.stage_data = {cur.sd2, cur.sd1, cur.sd0};

    // Reference model: list of instructions issued 1, 2, 3 cycles ago per DUT.
    bit         hv [2][3];
    logic [4:0] hr [2][3];
    bit         hl [2][3];
    bit         xst [2];

    function automatic int load_stage(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic in_t ins(input logic [6:0] op, input int rs1, input int e1,
                                input int rs2, input int e2, input int rd, input int rde,
                                input int imme, input int ld);
        in_t v;
        v.rst = 1'b0; v.dv = 1'b1; v.fl = 1'b0; v.op = op;
        v.rs1 = 5'(rs1); v.e1 = (e1 != 0); v.rs2 = 5'(rs2); v.e2 = (e2 != 0);
        v.rd = 5'(rd); v.rde = (rde != 0); v.imme = (imme != 0); v.ld = (ld != 0);
        v.pc = PC; v.imm = IMM; v.d1 = D1; v.d2 = D2;
        v.sd0 = '0; v.sd1 = '0; v.sd2 = '0;
        return v;
    endfunction

    function automatic vec_t mkv(input in_t v, input bit st, input int s1, input int s2,
                                 input bit co, input logic [31:0] o1, input logic [31:0] o2,
                                 input logic [31:0] sd);
        vec_t t;
        t.in = v; t.st = st; t.s1 = s1; t.s2 = s2; t.co = co; t.o1 = o1; t.o2 = o2; t.sd = sd;
        return t;
    endfunction

    task automatic find(input int d, input logic [4:0] rs, input logic en,
                        output int sel, output bit ld);
        sel = 0;
        ld  = 1'b0;
        if (en && rs != 0)
            for (int i = 0; i < 3; i++)
                if (sel == 0 && hv[d][i] && hr[d][i] == rs) begin
                    sel = i + 1;
                    ld  = hl[d][i];
                end
    endtask

    task automatic model_check(input int d);
        int s1, s2;
        bit l1, l2, st;
        logic [31:0] sdv [3];
        logic [31:0] f1, f2, o1, o2;
        logic        a_st;
        logic [1:0]  a_s1, a_s2;
        logic [31:0] a_o1, a_o2, a_sd;
        find(d, cur.rs1, cur.e1, s1, l1);
        find(d, cur.rs2, cur.e2, s2, l2);
        st = cur.dv && !cur.fl && ((l1 && (s1 - 1) < load_stage(d)) ||
                                   (l2 && (s2 - 1) < load_stage(d)));
        xst[d] = st;
        sdv = '{cur.sd0, cur.sd1, cur.sd2};
        f1 = (s1 == 0) ? cur.d1 : sdv[s1-1];
        f2 = (s2 == 0) ? cur.d2 : sdv[s2-1];
        if (cur.op == OP_BRANCH)    begin o1 = f1;     o2 = f2;      end
        else if (cur.op == OP_JAL)  begin o1 = cur.pc; o2 = cur.imm; end
        else if (cur.op == OP_JALR) begin o1 = f1;     o2 = cur.imm; end
        else begin o1 = f1; o2 = cur.imme ? cur.imm : f2; end
        if (d == 0) begin
            a_st = bus0.stall; a_s1 = bus0.fwd1_sel; a_s2 = bus0.fwd2_sel;
            a_o1 = bus0.op1;   a_o2 = bus0.op2;      a_sd = bus0.store_data;
        end else begin
            a_st = bus1.stall; a_s1 = bus1.fwd1_sel; a_s2 = bus1.fwd2_sel;
            a_o1 = bus1.op1;   a_o2 = bus1.op2;      a_sd = bus1.store_data;
        end
        chk($sformatf("model dut%0d stall", d), 32'(a_st), 32'(st));
        chk($sformatf("model dut%0d fwd1_sel", d), 32'(a_s1), 32'(s1));
        chk($sformatf("model dut%0d fwd2_sel", d), 32'(a_s2), 32'(s2));
        if (!st) begin
            chk($sformatf("model dut%0d op1", d), a_o1, o1);
            chk($sformatf("model dut%0d op2", d), a_o2, o2);
            chk($sformatf("model dut%0d store_data", d), a_sd, f2);
        end
    endtask

    task automatic model_commit();
        for (int d = 0; d < 2; d++) begin
            if (cur.rst) begin
                for (int i = 0; i < 3; i++) begin
                    hv[d][i] = 1'b0; hr[d][i] = '0; hl[d][i] = 1'b0;
                end
            end else begin
                for (int i = 2; i > 0; i--) begin
                    hv[d][i] = hv[d][i-1]; hr[d][i] = hr[d][i-1]; hl[d][i] = hl[d][i-1];
                end
                hv[d][0] = cur.dv && cur.rde && (cur.rd != 0) && !xst[d] && !cur.fl;
                hr[d][0] = cur.rd;
                hl[d][0] = cur.ld;
            end
        end
    endtask

    task automatic step_begin(input in_t v);
        cur = v;
        #2;
        model_check(0);
        model_check(1);
    endtask

    task automatic step_end();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic tbl_check(input int k, input vec_t t);
        chk($sformatf("vec%0d stall", k), 32'(bus0.stall), 32'(t.st));
        chk($sformatf("vec%0d fwd1_sel", k), 32'(bus0.fwd1_sel), 32'(t.s1));
        chk($sformatf("vec%0d fwd2_sel", k), 32'(bus0.fwd2_sel), 32'(t.s2));
        if (t.co) begin
            chk($sformatf("vec%0d op1", k), bus0.op1, t.o1);
            chk($sformatf("vec%0d op2", k), bus0.op2, t.o2);
            chk($sformatf("vec%0d store_data", k), bus0.store_data, t.sd);
        end
    endtask

    vec_t tbl [23];

    initial begin
        in_t v;
        in_t rv;
        logic [6:0] ops [7];
        ops = '{OP_BRANCH, OP_JAL, OP_JALR, OP_LOAD, OP_STORE, OP_ALU, OP_IMM};

        rv = ins(OP_ALU, 0, 0, 0, 0, 0, 0, 0, 0);
        rv.rst = 1'b1;
        rv.dv  = 1'b0;

        // Directed history (LOAD_STAGE=1 unit); comments give the instruction.
        v = ins(OP_ALU, 5, 1, 6, 1, 10, 1, 0, 0);                    // add x10,x5,x6
        tbl[0] = mkv(v, 0, 0, 0, 1, D1, D2, D2);
        v = ins(OP_IMM, 1, 1, 0, 0, 3, 1, 1, 0);                     // addi x3,x1
        tbl[1] = mkv(v, 0, 0, 0, 1, D1, IMM, D2);
        v = ins(OP_ALU, 3, 1, 7, 1, 4, 1, 0, 0); v.sd0 = 32'h11;     // add x4,x3,x7
        tbl[2] = mkv(v, 0, 1, 0, 1, 32'h11, D2, D2);
        v = ins(OP_LOAD, 0, 1, 0, 0, 8, 1, 1, 1);                    // lw x8
        tbl[3] = mkv(v, 0, 0, 0, 1, D1, IMM, D2);
        v = ins(OP_ALU, 8, 1, 1, 1, 9, 1, 0, 0);                     // add x9,x8,x1
        tbl[4] = mkv(v, 1, 1, 0, 0, 0, 0, 0);
        v.sd1 = 32'hDEAD_BEEF;
        tbl[5] = mkv(v, 0, 2, 0, 1, 32'hDEAD_BEEF, D2, D2);
        v = ins(OP_IMM, 1, 1, 0, 0, 2, 1, 1, 0);                     // addi x2
        tbl[6] = mkv(v, 0, 0, 0, 1, D1, IMM, D2);
        v = ins(OP_IMM, 1, 1, 0, 0, 11, 1, 1, 0);                    // addi x11
        tbl[7] = mkv(v, 0, 0, 0, 1, D1, IMM, D2);
        v = ins(OP_IMM, 1, 1, 0, 0, 2, 1, 1, 0);                     // addi x2
        tbl[8] = mkv(v, 0, 0, 0, 1, D1, IMM, D2);
        v = ins(OP_STORE, 1, 1, 2, 1, 0, 0, 1, 0);                   // sw x2
        v.sd0 = 32'hA; v.sd1 = 32'h77; v.sd2 = 32'hB;
        tbl[9] = mkv(v, 0, 0, 1, 1, D1, IMM, 32'hA);
        v = ins(OP_IMM, 0, 1, 0, 0, 0, 1, 1, 0);                     // addi x0,x0,5
        tbl[10] = mkv(v, 0, 0, 0, 1, D1, IMM, D2);
        v = ins(OP_ALU, 0, 1, 0, 1, 1, 1, 0, 0);                     // add x1,x0,x0
        tbl[11] = mkv(v, 0, 0, 0, 1, D1, D2, D2);
        v = ins(OP_LOAD, 1, 1, 0, 0, 12, 1, 1, 1); v.sd0 = 32'h3;    // lw x12,(x1)
        tbl[12] = mkv(v, 0, 1, 0, 1, 32'h3, IMM, D2);
        v = ins(7'b0110111, 12, 0, 12, 0, 13, 1, 1, 0);              // lui x13
        tbl[13] = mkv(v, 0, 0, 0, 1, D1, IMM, D2);
        v = ins(OP_LOAD, 0, 1, 0, 0, 14, 1, 1, 1);                   // lw x14
        tbl[14] = mkv(v, 0, 0, 0, 1, D1, IMM, D2);
        v = ins(OP_ALU, 14, 1, 0, 1, 15, 1, 0, 0); v.fl = 1'b1; v.sd0 = 32'h5;
        tbl[15] = mkv(v, 0, 1, 0, 1, 32'h5, D2, D2);
        v.fl = 1'b0; v.sd0 = '0; v.sd1 = 32'h66;
        tbl[16] = mkv(v, 0, 2, 0, 1, 32'h66, D2, D2);
        v = ins(OP_LOAD, 0, 1, 0, 0, 16, 1, 1, 1);                   // lw x16
        tbl[17] = mkv(v, 0, 0, 0, 1, D1, IMM, D2);
        v = ins(OP_ALU, 16, 1, 1, 1, 17, 1, 0, 0); v.rst = 1'b1;     // add x17 under rst
        tbl[18] = mkv(v, 1, 1, 0, 0, 0, 0, 0);
        v.rst = 1'b0;
        tbl[19] = mkv(v, 0, 0, 0, 1, D1, D2, D2);
        v = ins(OP_ALU, 17, 1, 17, 1, 18, 1, 0, 0); v.sd0 = 32'h99;  // add x18,x17,x17
        tbl[20] = mkv(v, 0, 1, 1, 1, 32'h99, 32'h99, 32'h99);
        v = ins(OP_BRANCH, 18, 1, 17, 1, 0, 0, 0, 0);                // beq x18,x17
        v.sd0 = 32'h42; v.sd1 = 32'h99;
        tbl[21] = mkv(v, 0, 1, 2, 1, 32'h42, 32'h99, 32'h99);
        v = ins(OP_JAL, 0, 0, 0, 0, 1, 1, 0, 0);                     // jal x1
        tbl[22] = mkv(v, 0, 0, 0, 1, PC, IMM, D2);

        cur = rv;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            step_begin(rv);
            step_end();
        end

        for (int k = 0; k < 23; k++) begin
            step_begin(tbl[k].in);
            tbl_check(k, tbl[k]);
            step_end();
        end

        // LOAD_STAGE=2 unit: back-to-back load-use stalls two cycles.
        for (int k = 0; k < 2; k++) begin
            step_begin(rv);
            step_end();
        end
        v = ins(OP_LOAD, 0, 1, 0, 0, 8, 1, 1, 1);
        step_begin(v);
        step_end();
        v = ins(OP_ALU, 8, 1, 1, 1, 9, 1, 0, 0);
        v.sd2 = 32'hDEAD_BEEF;
        for (int k = 0; k < 3; k++) begin
            step_begin(v);
            chk($sformatf("ls2 stall c%0d", k), 32'(bus1.stall), (k < 2) ? 32'd1 : 32'd0);
            chk($sformatf("ls2 fwd1_sel c%0d", k), 32'(bus1.fwd1_sel), 32'(k + 1));
            if (k == 2) chk("ls2 op1", bus1.op1, 32'hDEAD_BEEF);
            step_end();
        end

        for (int n = 0; n < 800; n++) begin
            v = ins(ops[$urandom_range(0, 6)], 0, 0, 0, 0, 0, 0, 0, 0);
            v.rs1  = 5'($urandom_range(0, 7));
            v.rs2  = 5'($urandom_range(0, 7));
            v.rd   = 5'($urandom_range(0, 7));
            v.e1   = ($urandom_range(0, 3) != 0);
            v.e2   = ($urandom_range(0, 3) != 0);
            v.rde  = ($urandom_range(0, 3) != 0);
            v.imme = ($urandom_range(0, 1) == 1);
            v.ld   = (v.op == OP_LOAD);
            v.dv   = ($urandom_range(0, 3) != 0);
            v.fl   = ($urandom_range(0, 9) == 0);
            v.rst  = ($urandom_range(0, 59) == 0);
            v.pc   = $urandom; v.imm = $urandom;
            v.d1   = $urandom; v.d2  = $urandom;
            v.sd0  = $urandom; v.sd1 = $urandom; v.sd2 = $urandom;
            step_begin(v);
            step_end();
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
`default_nettype wire
